// File: rtl/jtag_scan_master.sv
// jtag_scan_master: sequences one JTAG scan per request.
// A request is a DR scan, an IR scan, or a TAP reset. It is driven out on
// tck_o/tms_o/tdi_o, and the bits captured from tdo_i are returned as a response.
//
// Ports
//   clk, rst                 system clock, synchronous active-high reset
//   req_valid/req_ready      request handshake (op, len, data latched on accept)
//   req_op                   00 DR scan, 01 IR scan, 10 TAP reset, 11 reserved
//   req_len, req_data        shift length and TDI bits (LSB first)
//   rsp_valid/rsp_ready      response handshake
//   rsp_data, rsp_err        captured TDO bits, request-rejected flag
//   tck_o, tms_o, tdi_o      JTAG outputs
//   trstn_o                  TAP reset, low only while rst is applied
//   tdo_i                    JTAG input
//
// state   | meaning
// S_IDLE  | TAP parked in Run-Test/Idle, waiting for a request
// S_RESET | TMS=1 for five periods, then TMS=0 for one period
// S_HDR   | walk from Run-Test/Idle to Shift-DR or Shift-IR
// S_SHIFT | one period per bit; TMS=1 on the last bit (exit to Exit1)
// S_TAIL  | Exit1 -> Update -> Run-Test/Idle
// S_RESP  | response held until rsp_ready
module jtag_scan_master #(
  parameter int CLK_DIV = 4,
  parameter int MAX_LEN = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [1:0]         req_op,
  input  logic [6:0]         req_len,
  input  logic [MAX_LEN-1:0] req_data,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [MAX_LEN-1:0] rsp_data,
  output logic               rsp_err,
  output logic               tck_o,
  output logic               tms_o,
  output logic               tdi_o,
  output logic               trstn_o,
  input  logic               tdo_i
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RESET = 3'd1,
    S_HDR   = 3'd2,
    S_SHIFT = 3'd3,
    S_TAIL  = 3'd4,
    S_RESP  = 3'd5
  } state_t;

  localparam logic [7:0] LP_DIV_LAST = 8'(CLK_DIV - 1);
  localparam logic [7:0] LP_MAX_LEN  = 8'(MAX_LEN);

  state_t               r_state;
  logic [7:0]           r_div;
  logic                 r_tck;
  logic                 r_tms;
  logic                 r_tdi;
  logic [6:0]           r_cnt;
  logic                 r_ir;
  logic [6:0]           r_len;
  logic [MAX_LEN-1:0]   r_sh;
  logic [MAX_LEN-1:0]   r_cap;
  logic                 r_err;
  logic                 r_trstn;

  state_t               w_state_nxt;
  logic [6:0]           w_cnt_nxt;
  logic [MAX_LEN-1:0]   w_sh_nxt;
  logic                 w_ir_nxt;
  logic [6:0]           w_len_nxt;
  logic                 w_load;
  logic                 w_tms_nxt;
  logic                 w_tdi_nxt;
  logic                 w_active;
  logic                 w_div_end;
  logic                 w_fall;
  logic                 w_rise;
  logic                 w_last;
  logic                 w_accept;
  logic                 w_bad;

  assign req_ready = (r_state == S_IDLE) && r_trstn;
  assign rsp_valid = (r_state == S_RESP);
  assign rsp_data  = r_cap;
  assign rsp_err   = r_err;
  assign tck_o     = r_tck;
  assign tms_o     = r_tms;
  assign tdi_o     = r_tdi;
  assign trstn_o   = r_trstn;

  assign w_accept  = req_valid && req_ready;
  assign w_bad     = (req_len == 7'd0) || ({1'b0, req_len} > LP_MAX_LEN) || (req_op == 2'b11);

  assign w_active  = (r_state == S_RESET) || (r_state == S_HDR) ||
                     (r_state == S_SHIFT) || (r_state == S_TAIL);
  assign w_div_end = w_active && (r_div == LP_DIV_LAST);
  // a period ends at the close of its high phase; the next one starts low
  assign w_fall    = w_div_end && r_tck;
  assign w_rise    = w_div_end && !r_tck;

  always_comb begin
    w_last = 1'b0;
    unique case (r_state)
      S_RESET: w_last = (r_cnt == 7'd5);
      S_HDR:   w_last = r_ir ? (r_cnt == 7'd3) : (r_cnt == 7'd2);
      S_SHIFT: w_last = (r_cnt == r_len - 7'd1);
      S_TAIL:  w_last = (r_cnt == 7'd1);
      default: w_last = 1'b0;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_sh_nxt    = r_sh;
    w_ir_nxt    = r_ir;
    w_len_nxt   = r_len;
    w_load      = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_load    = 1'b1;
          w_cnt_nxt = 7'd0;
          w_sh_nxt  = req_data;
          w_ir_nxt  = (req_op == 2'b01);
          w_len_nxt = req_len;
          if (w_bad)                  w_state_nxt = S_RESP;
          else if (req_op == 2'b10)   w_state_nxt = S_RESET;
          else                        w_state_nxt = S_HDR;
        end
      end
      S_RESET, S_HDR, S_SHIFT, S_TAIL: begin
        if (w_fall) begin
          w_load = 1'b1;
          if (r_state == S_SHIFT) w_sh_nxt = r_sh >> 1;
          if (w_last) begin
            w_cnt_nxt = 7'd0;
            unique case (r_state)
              S_HDR:   w_state_nxt = S_SHIFT;
              S_SHIFT: w_state_nxt = S_TAIL;
              default: w_state_nxt = S_RESP;
            endcase
          end else begin
            w_cnt_nxt = r_cnt + 7'd1;
          end
        end
      end
      S_RESP: begin
        if (rsp_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // TMS/TDI for the period that is about to start
  always_comb begin
    w_tms_nxt = 1'b0;
    unique case (w_state_nxt)
      S_RESET: w_tms_nxt = (w_cnt_nxt != 7'd5);
      S_HDR:   w_tms_nxt = w_ir_nxt ? (w_cnt_nxt <= 7'd1) : (w_cnt_nxt == 7'd0);
      S_SHIFT: w_tms_nxt = (w_cnt_nxt == w_len_nxt - 7'd1);
      S_TAIL:  w_tms_nxt = (w_cnt_nxt == 7'd0);
      default: w_tms_nxt = 1'b0;
    endcase
    w_tdi_nxt = (w_state_nxt == S_SHIFT) ? w_sh_nxt[0] : 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_div   <= 8'd0;
      r_tck   <= 1'b0;
      r_tms   <= 1'b0;
      r_tdi   <= 1'b0;
      r_cnt   <= 7'd0;
      r_ir    <= 1'b0;
      r_len   <= 7'd0;
      r_sh    <= '0;
      r_cap   <= '0;
      r_err   <= 1'b0;
      r_trstn <= 1'b0;
    end else begin
      r_trstn <= 1'b1;
      r_div   <= (w_active && !w_div_end) ? r_div + 8'd1 : 8'd0;
      r_tck   <= w_active && (w_div_end ? !r_tck : r_tck);
      r_cnt   <= w_cnt_nxt;
      r_ir    <= w_ir_nxt;
      r_len   <= w_len_nxt;
      r_sh    <= w_sh_nxt;
      if (w_load) begin
        r_tms <= w_tms_nxt;
        r_tdi <= w_tdi_nxt;
      end
      if (w_accept) begin
        r_cap <= '0;
        r_err <= w_bad;
      end else if (w_rise && (r_state == S_SHIFT)) begin
        for (int i = 0; i < MAX_LEN; i++) begin
          if (r_cnt == 7'(i)) r_cap[i] <= tdo_i;
        end
      end
    end
  end

endmodule

// File: doc/jtag_scan_master.md
JTAG_SCAN_MASTER -- requirements
Module: jtag_scan_master

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4, meaning clk cycles per TCK half-period (legal 2..255).
REQ-002 SHALL have parameter MAX_LEN, default 64, meaning maximum scan length in bits.
REQ-003 SHALL use one clock; reset is synchronous and active-high: ports clk (input, 1, system clock) and rst (input, 1, synchronous active-high reset).
REQ-004 SHALL have port req_valid, input, 1: a scan request is presented.
REQ-005 SHALL have port req_ready, output, 1: the block is idle and accepts a request.
REQ-006 SHALL have port req_op, input, 2: 00 DR scan, 01 IR scan, 10 TAP reset, 11 reserved (error).
REQ-007 SHALL have port req_len, input, 7: number of bits to shift.
REQ-008 SHALL have port req_data, input, MAX_LEN: TDI bits, LSB shifted first.
REQ-009 SHALL have port rsp_valid, output, 1: response available.
REQ-010 SHALL have port rsp_ready, input, 1: consumer accepts the response.
REQ-011 SHALL have port rsp_data, output, MAX_LEN: captured TDO bits.
REQ-012 SHALL have port rsp_err, output, 1: the request was rejected.
REQ-013 SHALL have ports tck_o, tms_o, tdi_o, trstn_o (outputs, 1 bit each) and tdo_i (input, 1) as JTAG pins.

Function
REQ-014 SHALL accept a request on a clk edge where req_valid and req_ready are both 1, and SHALL latch op, len and data at that edge.
REQ-015 SHALL drive req_ready=1 only in state IDLE with rsp_valid=0.
REQ-016 SHALL use states IDLE, RESET, HDR, SHIFT, TAIL and RESP.
REQ-017 SHALL generate each TCK period as CLK_DIV clk cycles with tck_o=0 followed by CLK_DIV clk cycles with tck_o=1.
REQ-018 SHALL update tms_o/tdi_o only on the clk cycle where tck_o goes 0 after the previous high phase, or at the start of the first low phase.
REQ-019 SHALL sample tdo_i on the clk edge that drives tck_o 0->1.
REQ-020 SHALL hold tck_o=0 whenever the block is not in RESET, HDR, SHIFT or TAIL.
REQ-021 For a DR scan, the TMS sequence SHALL be 1,0,0 (HDR), then N shift bits with TMS=0 for bits 0..N-2 and TMS=1 for bit N-1, then 1,0 (TAIL): N+5 TCK periods in total.
REQ-022 For an IR scan, the HDR sequence SHALL be 1,1,0,0, giving N+6 TCK periods in total.
REQ-023 tdi_o SHALL equal req_data[i] during shift bit i; tdi_o SHALL be 0 outside SHIFT.
REQ-024 rsp_data[i] SHALL equal the tdo_i sample taken on shift bit i for i<N, and rsp_data[MAX_LEN-1:N] SHALL be 0.
REQ-025 TAP reset SHALL drive TMS=1 for 5 TCK periods, then TMS=0 for 1 period, and SHALL return rsp_data=0.
REQ-026 If req_len=0, req_len>MAX_LEN or req_op=11, the block SHALL toggle no TCK and SHALL enter RESP the cycle after acceptance with rsp_err=1 and rsp_data=0.
REQ-027 In RESP, rsp_valid SHALL be 1 and rsp_data/rsp_err SHALL be stable until the rsp_valid&rsp_ready edge; the block SHALL then return to IDLE.
REQ-028 rsp_valid SHALL rise on the clk edge ending the final TCK high phase of a scan (latency 2*CLK_DIV*periods clk cycles after acceptance, +0/+1 cycle allowed).
REQ-029 The block SHALL hold the TAP in Run-Test/Idle in IDLE: tms_o=0, tck_o=0.
REQ-030 A request arriving while req_ready=0 SHALL not be accepted, and inputs SHALL be ignored until req_ready=1.
REQ-031 The divider counter SHALL wrap from CLK_DIV-1 to 0, and the bit counter SHALL be 7 bits wide with no wrap beyond MAX_LEN.

Reset
REQ-032 On rst=1 the block SHALL enter IDLE and drive tck_o=0, tms_o=0, tdi_o=0, trstn_o=0, req_ready=0, rsp_valid=0, rsp_err=0 and rsp_data=0.
REQ-033 The cycle after rst falls, the block SHALL drive trstn_o=1 and req_ready=1.
REQ-034 rst asserted mid-scan SHALL abort immediately: no response is generated and all outputs take their REQ-032 values on the next edge.

Verification
REQ-035 The bench SHALL cover a DR scan with len=8, data=0xA5, tdo looped from a shift-register model preset 0x3C -> 13 TCK periods, TDI bit order 1,0,1,0,0,1,0,1, rsp_data=0x3C, rsp_err=0, rsp_valid at clk 104 (±1) with CLK_DIV=4.
REQ-036 The bench SHALL cover an IR scan with len=5, data=0x01 -> TMS stream 1,1,0,0,0,0,0,0,1,1,0 and 11 TCK periods.
REQ-037 The bench SHALL cover a TAP reset -> TMS 1,1,1,1,1,0, 6 periods, rsp_data=0.
REQ-038 The bench SHALL cover a len=0 request, a len=65 request and a req_op=11 request -> no TCK edge, rsp_err=1 one cycle after acceptance.
REQ-039 The bench SHALL cover a len=64 scan of all-ones data with tdo=1 -> rsp_data=0xFFFF_FFFF_FFFF_FFFF and 69 periods; rsp_ready held 0 for 10 cycles -> rsp_valid and rsp_data stable, req_ready=0 throughout.
REQ-040 The bench SHALL cover rst asserted at TCK period 4 of a DR scan -> tck_o=0 and rsp_valid=0 the next cycle, and req_ready=1 the cycle after rst falls.
